// File: rtl/serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_sub
// Description : Bit-serial two's-complement adder/subtractor. It adds one bit
//               per clock, LSB first, using one full-adder cell and a carry
//               flop. A start request loads the operands. A one-cycle done
//               pulse goes with the registered result.
// Revision    : 1.0  initial release
// ============================================================================
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  // The counter must be able to hold WIDTH, because it is incremented once
  // more on the final bit edge.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  // Holds only the upper WIDTH-1 bits of the sum built so far. The bit
  // produced on the current edge comes from w_s and completes the word.
  logic [WIDTH-2:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_ovf;

  logic             w_s;
  logic             w_cout;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_next;

  // Single full-adder cell working on the current LSBs.
  assign w_s        = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_cout     = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_last     = (r_cnt == CW'(WIDTH - 1));
  assign w_sum_next = {w_s, r_sum};

  // Control FSM and datapath. r_carry is the carry into the bit being
  // processed. On the last edge it is therefore the carry into the MSB,
  // which is what the signed overflow test needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_sum    <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_sub   <= sub;
            r_carry <= sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_carry <= w_cout;
          r_sum   <= w_sum_next[WIDTH-1:1];
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_sum_next;
            r_cout   <= r_sub ? ~w_cout : w_cout;
            r_ovf    <= r_carry ^ w_cout;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result    = r_result;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_sub
// Description : Self-checking bench for serial_add_sub. It uses an 8-bit and a
//               4-bit instance. Checks come from vector tables, randomized
//               operations against an arithmetic model, and hand-written
//               multi-cycle sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       st8 = 0, sb8 = 0, bsy8, dn8, co8, ov8;
  logic [7:0] a8 = 0, b8 = 0, res8;
  logic       st4 = 0, sb4 = 0, bsy4, dn4, co4, ov4;
  logic [3:0] a4 = 0, b4 = 0, res4;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(st8), .sub(sb8), .a(a8), .b(b8),
    .busy(bsy8), .done(dn8), .result(res8), .carry_out(co8), .overflow(ov8)
  );

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .sub(sb4), .a(a4), .b(b4),
    .busy(bsy4), .done(dn4), .result(res4), .carry_out(co4), .overflow(ov4)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned and signed views.
  task automatic model(input int w, input int a, input int b, input bit s,
                       output int res, output bit co, output bit ov);
    int m, raw, sa, sbv, sr;
    m   = 1 << w;
    raw = s ? a - b : a + b;
    res = ((raw % m) + m) % m;
    co  = s ? (a < b) : (raw >= m);
    sa  = (a >= m / 2) ? a - m : a;
    sbv = (b >= m / 2) ? b - m : b;
    sr  = s ? sa - sbv : sa + sbv;
    ov  = (sr < -(m / 2)) || (sr >= m / 2);
  endtask

  // Call only at a negedge. The request is presented for exactly one
  // rising edge (E0), and the task returns at the negedge after E0.
  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic s);
    st8 = 1; a8 = a; b8 = b; sb8 = s;
    @(negedge clk);
    st8 = 0; a8 = $urandom; b8 = $urandom; sb8 = $urandom;
  endtask

  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic s);
    st4 = 1; a4 = a; b4 = b; sb4 = s;
    @(negedge clk);
    st4 = 0; a4 = $urandom; b4 = $urandom; sb4 = $urandom;
  endtask

  // n = number of rising edges since E0. A correct DUT returns n == WIDTH.
  task automatic wait8(input int n0, output int n, output int bcnt, output bit held);
    logic [7:0] r0;
    r0 = res8; n = n0; bcnt = 0; held = 1;
    while (!dn8 && n <= 40) begin
      if (bsy8) bcnt++;
      if (res8 !== r0) held = 0;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait4(output int n);
    n = 0;
    while (!dn4 && n <= 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] res;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vt[7];

  initial begin
    int  n, bcnt, er, dcnt;
    bit  held, eco, eov;

    vt[0] = '{8'h3A, 8'h25, 1'b0, 8'h5F, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b1, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b0, 1'b1};
    vt[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bsy8), 0);
    chk("reset done", 32'(dn8), 0);
    chk("reset result", 32'(res8), 0);
    chk("reset carry", 32'(co8), 0);
    chk("reset ovf", 32'(ov8), 0);
    rst_n = 1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      start8(vt[i].a, vt[i].b, vt[i].s);
      wait8(0, n, bcnt, held);
      chk($sformatf("vec%0d latency", i), n, 8);
      chk($sformatf("vec%0d busy cycles", i), bcnt, 8);
      chk($sformatf("vec%0d result", i), 32'(res8), 32'(vt[i].res));
      chk($sformatf("vec%0d carry", i), 32'(co8), 32'(vt[i].co));
      chk($sformatf("vec%0d ovf", i), 32'(ov8), 32'(vt[i].ov));
      chk($sformatf("vec%0d busy at done", i), 32'(bsy8), 0);
      @(negedge clk);
      chk($sformatf("vec%0d done one cycle", i), 32'(dn8), 0);
    end

    // Randomized operations against the model.
    for (int i = 0; i < 150; i++) begin
      logic [7:0] ra, rb;
      logic       rs;
      ra = $urandom; rb = $urandom; rs = $urandom;
      model(8, int'(ra), int'(rb), rs, er, eco, eov);
      start8(ra, rb, rs);
      wait8(0, n, bcnt, held);
      chk("rand latency", n, 8);
      chk("rand result", 32'(res8), er);
      chk("rand carry", 32'(co8), 32'(eco));
      chk("rand ovf", 32'(ov8), 32'(eov));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // A start during RUN is ignored. A start during the DONE cycle is
    // accepted back-to-back.
    @(negedge clk);
    start8(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    st8 = 1; a8 = 8'hFF; b8 = 8'hFF; sb8 = 1'b0;
    @(negedge clk);
    st8 = 0;
    wait8(3, n, bcnt, held);
    chk("ignore latency", n, 8);
    chk("ignore result", 32'(res8), 32'h30);
    start8(8'h30, 8'h10, 1'b1);
    chk("b2b done cleared", 32'(dn8), 0);
    chk("b2b busy", 32'(bsy8), 1);
    chk("b2b result hold", 32'(res8), 32'h30);
    wait8(0, n, bcnt, held);
    chk("b2b latency", n, 8);
    chk("b2b held between", 32'(held), 1);
    chk("b2b result", 32'(res8), 32'h20);
    chk("b2b borrow", 32'(co8), 0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start8(8'hAA, 8'h55, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async rst busy", 32'(bsy8), 0);
    chk("async rst done", 32'(dn8), 0);
    chk("async rst result", 32'(res8), 0);
    chk("async rst carry", 32'(co8), 0);
    chk("async rst ovf", 32'(ov8), 0);
    @(negedge clk);
    rst_n = 1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dn8 || bsy8) dcnt++;
    end
    chk("no done after abort", dcnt, 0);
    start8(8'h01, 8'h01, 1'b0);
    wait8(0, n, bcnt, held);
    chk("post rst latency", n, 8);
    chk("post rst result", 32'(res8), 32'h02);

    // Exhaustive 4-bit sweep.
    @(negedge clk);
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int is = 0; is < 2; is++) begin
          model(4, ia, ib, is[0], er, eco, eov);
          start4(4'(ia), 4'(ib), is[0]);
          wait4(n);
          chk("w4 latency", n, 4);
          chk("w4 result", 32'(res4), er);
          chk("w4 carry", 32'(co4), 32'(eco));
          chk("w4 ovf", 32'(ov4), 32'(eov));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
Bit-serial, parametrised-width adder/subtractor that processes one bit per clock, LSB first, using a single full-adder cell and a carry flip-flop. It is the sequential successor to the single-bit combinational gate primitives in the binary-add library. It is intended for area-constrained datapaths that can trade latency for logic. Operands are captured on a start handshake, and a one-cycle done pulse accompanies the registered result.

Parameters:
WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled when not busy
sub  input  1  0 = a+b, 1 = a-b (two's complement); captured with start
a  input  WIDTH  operand A; captured with start
b  input  WIDTH  operand B; captured with start
busy  output  1  high while the operation is in progress (RUN state)
done  output  1  one-cycle pulse when result is valid
result  output  WIDTH  sum/difference; holds value until the next completion
carry_out  output  1  add: carry out of MSB; sub: borrow (1 when unsigned a < b)
overflow  output  1  signed overflow of the last operation

Behaviour:
- One clock domain (clk) with asynchronous active-low reset (rst_n).
- Reset:
  - rst_n low immediately forces state IDLE.
  - busy, done, result, carry_out and overflow all read 0.
  - Internal shift registers, bit counter and carry are cleared.
  - Reset mid-operation aborts the operation; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - Latch a into opA_sr.
  - Latch (sub ? ~b : b) into opB_sr.
  - Latch sub.
  - Set carry to sub (provides the +1 of two's complement).
  - Set bit_cnt to 0 and move to RUN.
- IDLE/DONE with start=0: go to (or stay in) IDLE.
- DONE lasts exactly one cycle.
- RUN, each edge:
  - s = opA_sr[0] ^ opB_sr[0] ^ carry.
  - carry <= majority(opA_sr[0], opB_sr[0], carry).
  - Shift s into the MSB of the sum shift register; shift both operand registers right by one.
  - bit_cnt increments.
  - On the edge processing bit WIDTH-1, record the carry into the MSB (for overflow).
  - That same edge is edge E_WIDTH; at it, move to DONE.
- Completion, at edge E_WIDTH:
  - result <= final sum.
  - carry_out <= sub ? ~cout : cout.
  - overflow <= carry_into_msb ^ cout.
  - done = 1 during the following cycle only.
- Latency: done is high exactly WIDTH cycles after the start-sampling edge.
- busy = (state == RUN), registered, with no combinational path from start.
- start while in RUN is ignored; captured operands are unaffected.
- start during the DONE cycle is accepted, giving back-to-back operation with no idle gap.
- a, b and sub are don't-care except at the accepting edge.
- result, carry_out and overflow change only at completion edges or on reset. They are never updated mid-operation.
- Arithmetic is modulo 2^WIDTH. No saturation.

Test Plan:
1. WIDTH=8, add 8'h3A + 8'h25, start one cycle -> busy high for 8 cycles; done pulse 8 cycles after the start edge; result=8'h5F, carry_out=0, overflow=0.
2. Add 8'hFF + 8'h01 -> result=8'h00, carry_out=1, overflow=0. Add 8'h7F + 8'h01 -> result=8'h80, carry_out=0, overflow=1.
3. Sub 8'h05 - 8'h07 -> result=8'hFE, carry_out(borrow)=1, overflow=0. Sub 8'h80 - 8'h01 -> result=8'h7F, borrow=0, overflow=1.
4. Add 8'h10 + 8'h20; at cycle 3 pulse start with a=8'hFF, b=8'hFF -> request ignored, result=8'h30. Then assert start during the done cycle with sub 8'h30 - 8'h10 -> second done exactly 8 cycles later, result=8'h20; result holds 8'h30 between the two completions.
5. Start add 8'hAA + 8'h55; drop rst_n asynchronously mid-cycle after 4 bit-edges -> all outputs 0 before the next clock edge, no done pulse. Release reset, then add 8'h01 + 8'h01 -> result=8'h02.
6. WIDTH=4 exhaustive: all 16x16 operand pairs x {add, sub} -> result, carry_out and overflow match a reference model; each done pulse arrives 4 cycles after its start edge.
